// File: rtl/stream_ones_zeros_counter.sv
// stream_ones_zeros_counter: accumulates 1/0 bit totals across a valid/ready framed word stream
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last   input word stream, in_last ends a frame
//   out_valid/out_ready            held per-frame result handshake
//   out_ones/out_zeros/out_words/out_overflow   frame totals (first MAX_WORDS words only)
module stream_ones_zeros_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = $clog2(WIDTH*MAX_WORDS+1),
    parameter int WCNT_W    = $clog2(MAX_WORDS+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_ones,
    output logic [CNT_W-1:0]  out_zeros,
    output logic [WCNT_W-1:0] out_words,
    output logic              out_overflow
);
    typedef enum logic {ACCUM, RESULT} state_t;
    state_t              r_state;
    logic [CNT_W-1:0]    r_ones, r_zeros, r_out_ones, r_out_zeros;
    logic [WCNT_W-1:0]   r_words, r_out_words;
    logic                r_ovf, r_out_ovf, r_out_valid;
    logic [CNT_W-1:0]    w_pop, w_ones_n, w_zeros_n;
    logic [WCNT_W-1:0]   w_words_n;
    logic                w_room, w_acc, w_ovf_n;
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) w_pop = w_pop + CNT_W'(in_data[i]);
    end
    // Once MAX_WORDS words are counted, further beats only raise the overflow flag
    assign w_room    = r_words < WCNT_W'(MAX_WORDS);
    assign w_acc     = in_valid && r_state == ACCUM;
    assign w_ones_n  = w_room ? r_ones + w_pop : r_ones;
    assign w_zeros_n = w_room ? r_zeros + (CNT_W'(WIDTH) - w_pop) : r_zeros;
    assign w_words_n = w_room ? r_words + WCNT_W'(1) : r_words;
    assign w_ovf_n   = r_ovf | ~w_room;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_ones      <= '0;
            r_zeros     <= '0;
            r_words     <= '0;
            r_ovf       <= 1'b0;
            r_out_ones  <= '0;
            r_out_zeros <= '0;
            r_out_words <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (r_state == ACCUM) begin
            if (w_acc && in_last) begin
                r_out_ones  <= w_ones_n;
                r_out_zeros <= w_zeros_n;
                r_out_words <= w_words_n;
                r_out_ovf   <= w_ovf_n;
                r_out_valid <= 1'b1;
                r_state     <= RESULT;
                r_ones      <= '0;
                r_zeros     <= '0;
                r_words     <= '0;
                r_ovf       <= 1'b0;
            end else if (w_acc) begin
                r_ones  <= w_ones_n;
                r_zeros <= w_zeros_n;
                r_words <= w_words_n;
                r_ovf   <= w_ovf_n;
            end
        end else if (out_ready) begin
            r_state     <= ACCUM;
            r_out_valid <= 1'b0;
        end
    end
    assign in_ready     = r_state == ACCUM;
    assign out_valid    = r_out_valid;
    assign out_ones     = r_out_ones;
    assign out_zeros    = r_out_zeros;
    assign out_words    = r_out_words;
    assign out_overflow = r_out_ovf;
endmodule

// File: tb/tb_stream_ones_zeros_counter.sv
// tb_stream_ones_zeros_counter: directed and randomized frames checked against a frame-level model
module tb_stream_ones_zeros_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, out_valid, out_overflow;
    logic [5:0] out_ones, out_zeros;
    logic [2:0] out_words;
    int         vectors = 0;
    int         errors = 0;
    logic [15:0] got, held;
    stream_ones_zeros_counter #(.WIDTH(8), .MAX_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ones(out_ones), .out_zeros(out_zeros), .out_words(out_words), .out_overflow(out_overflow)
    );
    always #5 clk = ~clk;
    assign got = {out_ones, out_zeros, out_words, out_overflow};
    function automatic logic [15:0] model(input logic [7:0] q[$]);
        int k = q.size() > 4 ? 4 : q.size();
        int o = 0;
        for (int i = 0; i < k; i++) o += $countones(q[i]);
        return {6'(o), 6'(8 * k - o), 3'(k), q.size() > 4};
    endfunction
    task automatic beat(input logic [7:0] d, input logic l);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL beat_ready in_ready=%b required 1", in_ready);
            errors++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask
    task automatic wait_valid();
        int t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
    endtask
    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready, got} !== {1'b0, 1'b1, 16'h0}) begin
            $display("FAIL reset valid/ready/outs=%b/%b/%h required 0/1/0000", out_valid, in_ready, got);
            errors++;
        end
    endtask
    task automatic test_single();
        logic [7:0] q[$] = '{8'hA5};
        beat(8'hA5, 1'b1);
        vectors++;
        if (out_valid !== 1'b1) begin
            $display("FAIL single_latency out_valid=%b required 1", out_valid);
            errors++;
        end
        vectors++;
        if (got !== model(q) || got !== {6'd4, 6'd4, 3'd1, 1'b0}) begin
            $display("FAIL single_totals got=%h required %h", got, model(q));
            errors++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if ({out_valid, in_ready, got} !== {1'b0, 1'b1, model(q)}) begin
            $display("FAIL single_release valid/ready/outs=%b/%b/%h required 0/1/%h", out_valid, in_ready, got, model(q));
            errors++;
        end
    endtask
    task automatic test_stall();
        logic [7:0] q[$] = '{8'hFF, 8'h00, 8'h0F};
        beat(8'hFF, 1'b0);
        repeat (2) @(negedge clk);
        beat(8'h00, 1'b0);
        @(negedge clk);
        beat(8'h0F, 1'b1);
        held = got;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({out_valid, in_ready, got} !== {1'b1, 1'b0, model(q)}) begin
                $display("FAIL stall_hold cyc=%0d valid/ready/outs=%b/%b/%h required 1/0/%h", c, out_valid, in_ready, got, model(q));
                errors++;
            end
            in_valid = 1'b1;
            in_last  = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (held !== {6'd12, 6'd12, 3'd3, 1'b0}) begin
            $display("FAIL stall_totals got=%h required %h", held, {6'd12, 6'd12, 3'd3, 1'b0});
            errors++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL stall_release valid/ready=%b/%b required 0/1", out_valid, in_ready);
            errors++;
        end
    endtask
    task automatic test_overflow();
        for (int i = 0; i < 6; i++) beat(8'hFF, i == 5);
        vectors++;
        if ({out_valid, got} !== {1'b1, 6'd32, 6'd0, 3'd4, 1'b1}) begin
            $display("FAIL ovf_totals valid/outs=%b/%h required 1/%h", out_valid, got, {6'd32, 6'd0, 3'd4, 1'b1});
            errors++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        beat(8'h01, 1'b1);
        vectors++;
        if ({out_valid, got} !== {1'b1, 6'd1, 6'd7, 3'd1, 1'b0}) begin
            $display("FAIL ovf_next valid/outs=%b/%h required 1/%h", out_valid, got, {6'd1, 6'd7, 3'd1, 1'b0});
            errors++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask
    task automatic test_back_to_back();
        beat(8'h80, 1'b1);
        vectors++;
        if ({out_valid, in_ready, got} !== {1'b1, 1'b0, 6'd1, 6'd7, 3'd1, 1'b0}) begin
            $display("FAIL b2b_first valid/ready/outs=%b/%b/%h required 1/0/%h", out_valid, in_ready, got, {6'd1, 6'd7, 3'd1, 1'b0});
            errors++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL b2b_gap valid/ready=%b/%b required 0/1", out_valid, in_ready);
            errors++;
        end
        beat(8'hFE, 1'b1);
        vectors++;
        if ({out_valid, got} !== {1'b1, 6'd7, 6'd1, 3'd1, 1'b0}) begin
            $display("FAIL b2b_second valid/outs=%b/%h required 1/%h", out_valid, got, {6'd7, 6'd1, 3'd1, 1'b0});
            errors++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask
    task automatic test_reset_midframe();
        int seen = 0;
        beat(8'hFF, 1'b0);
        beat(8'hFF, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL midrst_clear valid/ready=%b/%b required 0/1", out_valid, in_ready);
            errors++;
        end
        beat(8'h03, 1'b1);
        vectors++;
        if ({out_valid, got} !== {1'b1, 6'd2, 6'd6, 3'd1, 1'b0}) begin
            $display("FAIL midrst_totals valid/outs=%b/%h required 1/%h", out_valid, got, {6'd2, 6'd6, 3'd1, 1'b0});
            errors++;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        out_ready = 1'b0;
        vectors++;
        if (seen !== 0) begin
            $display("FAIL midrst_extra extra_results=%0d required 0", seen);
            errors++;
        end
    endtask
    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            logic [7:0] q[$];
            int n = $urandom_range(1, 7);
            q = {};
            for (int i = 0; i < n; i++) begin
                q.push_back(8'($urandom));
                beat(q[i], i == n - 1);
                if (i != n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_valid();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            vectors++;
            if ({out_valid, in_ready, got} !== {1'b1, 1'b0, model(q)}) begin
                $display("FAIL rand_frame f=%0d n=%0d valid/ready/outs=%b/%b/%h required 1/0/%h", f, n, out_valid, in_ready, got, model(q));
                errors++;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask
    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
